// File: rtl/md_scheduler_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op codes, FSM states, datapath width.
package md_scheduler_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product and 32-bit quotient/remainder for the latched operands.
module md_arith
  import md_scheduler_pkg::*;
(
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  input  logic              i_signed,
  output logic [2*XLEN-1:0] o_prod,
  output logic [XLEN-1:0]   o_quot,
  output logic [XLEN-1:0]   o_rem,
  output logic              o_div_zero
);

  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_b_ext;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_b_safe;
  logic [XLEN-1:0]   w_q_mag;
  logic [XLEN-1:0]   w_r_mag;

  assign w_a_ext = i_signed ? {{XLEN{i_a[XLEN-1]}}, i_a} : {{XLEN{1'b0}}, i_a};
  assign w_b_ext = i_signed ? {{XLEN{i_b[XLEN-1]}}, i_b} : {{XLEN{1'b0}}, i_b};
  assign o_prod  = w_a_ext * w_b_ext;

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000 rem 0.
  assign w_a_neg    = i_signed & i_a[XLEN-1];
  assign w_b_neg    = i_signed & i_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~i_a + XLEN'(1)) : i_a;
  assign w_b_mag    = w_b_neg ? (~i_b + XLEN'(1)) : i_b;
  assign o_div_zero = (i_b == '0);
  assign w_b_safe   = o_div_zero ? XLEN'(1) : w_b_mag;
  assign w_q_mag    = w_a_mag / w_b_safe;
  assign w_r_mag    = w_a_mag % w_b_safe;
  assign o_quot     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + XLEN'(1)) : w_q_mag;
  assign o_rem      = w_a_neg ? (~w_r_mag + XLEN'(1)) : w_r_mag;

endmodule

// File: rtl/md_scheduler.sv
// HI/LO owner and multi-cycle scheduler for MULT/DIV; raises stall_md for D-stage consumers.
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_E,
  input  logic [2:0]      op_E,
  input  logic [XLEN-1:0] a_E,
  input  logic [XLEN-1:0] b_E,
  input  logic            md_use_D,
  output logic            busy,
  output logic            stall_md,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  md_state_e         r_state;
  md_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2:0]        r_op;
  logic              w_load;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic              w_div_zero;

  md_arith u_arith (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_signed   (md_is_signed(r_op)),
    .o_prod     (w_prod),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_div_zero (w_div_zero)
  );

  // Mult/div ops have op_E[2] == 0; MTHI/MTLO never stall.
  assign stall_md = md_use_D & (r_busy | (start_E & ~op_E[2]));
  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_E) begin
          case (op_E)
            MD_MULT, MD_MULTU: begin
              w_load      = 1'b1;
              w_cnt_nxt   = CNT_W'(MULT_LAT - 1);
              w_state_nxt = ST_MUL;
              w_busy_nxt  = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              w_load      = 1'b1;
              w_cnt_nxt   = CNT_W'(DIV_LAT - 1);
              w_state_nxt = ST_DIV;
              w_busy_nxt  = 1'b1;
            end
            MD_MTHI: w_hi_nxt = a_E;
            MD_MTLO: w_lo_nxt = a_E;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (r_cnt == '0) begin
          w_state_nxt          = ST_IDLE;
          w_busy_nxt           = 1'b0;
          {w_hi_nxt, w_lo_nxt} = w_prod;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          if (!w_div_zero) begin
            w_hi_nxt = w_rem;
            w_lo_nxt = w_quot;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      if (w_load) begin
        r_a  <= a_E;
        r_b  <= b_E;
        r_op <= op_E;
      end
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: latency, results, stall, MTHI/MTLO, reserved ops, reset abort.
module tb_md_scheduler;
  import md_scheduler_pkg::*;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start_E  = 1'b0;
  logic [2:0]  op_E     = 3'd0;
  logic [31:0] a_E      = 32'd0;
  logic [31:0] b_E      = 32'd0;
  logic        md_use_D = 1'b0;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass  = 0;
  int n_total = 0;

  md_scheduler #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_E  (start_E),
    .op_E     (op_E),
    .a_E      (a_E),
    .b_E      (b_E),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_E = 1'b1;
    op_E    = op;
    a_E     = a;
    b_E     = b;
  endtask

  // Start an op, scramble operands afterwards, and check busy/stall each cycle.
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input logic use_d);
    md_use_D = use_d;
    issue(op, a, b);
    #1;
    chk({tag, " stall_start"}, 32'(stall_md), 32'(use_d));
    tick();
    start_E = 1'b0;
    a_E     = ~a;
    b_E     = b ^ 32'h5A5A_A5A5;
    for (int i = 0; i < lat; i++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " stall_busy"}, 32'(stall_md), 32'(use_d));
      tick();
    end
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
    chk({tag, " stall_end"}, 32'(stall_md), 32'd0);
    md_use_D = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst stall", 32'(stall_md), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);

    // Start accepted on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    issue(MD_MTLO, 32'h5, 32'h0);
    tick();
    start_E = 1'b0;
    chk("first_edge lo", lo, 32'h5);

    run("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b1);
    chk("mult hi", hi, 32'hFFFF_FFFF);
    chk("mult lo", lo, 32'hFFFF_FFFA);

    md_use_D = 1'b1;
    issue(MD_MTHI, 32'h11, 32'h0);
    #1;
    chk("mthi stall", 32'(stall_md), 32'd0);
    tick();
    start_E = 1'b0;
    chk("mthi hi", hi, 32'h11);
    chk("mthi busy", 32'(busy), 32'd0);
    issue(MD_MTLO, 32'h22, 32'h0);
    tick();
    start_E  = 1'b0;
    md_use_D = 1'b0;
    chk("mtlo lo", lo, 32'h22);
    chk("mtlo hi", hi, 32'h11);

    run("divz", MD_DIV, 32'd5, 32'd0, 10, 1'b0);
    chk("divz hi", hi, 32'h11);
    chk("divz lo", lo, 32'h22);

    run("divu", MD_DIVU, 32'd100, 32'd7, 10, 1'b1);
    chk("divu lo", lo, 32'd14);
    chk("divu hi", hi, 32'd2);

    run("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
    chk("div lo", lo, 32'hFFFF_FFFD);
    chk("div hi", hi, 32'hFFFF_FFFF);

    run("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
    chk("divovf lo", lo, 32'h8000_0000);
    chk("divovf hi", hi, 32'h0);

    run("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);
    chk("multu hi", hi, 32'hFFFF_FFFE);
    chk("multu lo", lo, 32'h0000_0001);

    issue(3'd6, 32'h77, 32'h77);
    tick();
    issue(3'd7, 32'h88, 32'h88);
    tick();
    start_E = 1'b0;
    chk("rsvd busy", 32'(busy), 32'd0);
    chk("rsvd hi", hi, 32'hFFFF_FFFE);
    chk("rsvd lo", lo, 32'h0000_0001);

    // A start while busy must neither retarget the op nor extend busy.
    issue(MD_MULT, 32'd2, 32'd3);
    tick();
    start_E = 1'b0;
    tick();
    issue(MD_DIVU, 32'd100, 32'd7);
    tick();
    start_E = 1'b0;
    tick();
    tick();
    chk("ovl busy_last", 32'(busy), 32'd1);
    tick();
    chk("ovl busy_end", 32'(busy), 32'd0);
    chk("ovl hi", hi, 32'd0);
    chk("ovl lo", lo, 32'd6);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    tick();
    start_E = 1'b0;
    tick();
    tick();
    chk("abort pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) tick();
    chk("abort post busy", 32'(busy), 32'd0);
    chk("abort post hi", hi, 32'd0);
    chk("abort post lo", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 Parameter: MULT_LAT, default 5, busy cycles for MULT/MULTU.
REQ-002 Parameter: DIV_LAT, default 10, busy cycles for DIV/DIVU.
REQ-003 Port: clk  input  1  single clock, rising-edge active.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start_E  input  1  E-stage mult/div-class instruction valid this cycle.
REQ-006 Port: op_E  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others reserved.
REQ-007 Port: a_E  input  32  rs operand after E-stage forwarding.
REQ-008 Port: b_E  input  32  rt operand after E-stage forwarding.
REQ-009 Port: md_use_D  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 Port: busy  output  1  multi-cycle operation in progress.
REQ-011 Port: stall_md  output  1  request to freeze PC/IF-ID and bubble ID-EX.
REQ-012 Port: hi  output  32  architectural HI register.
REQ-013 Port: lo  output  32  architectural LO register.

Function
REQ-014 The block SHALL implement FSM states IDLE, MUL, DIV plus a down-counter sized for max(MULT_LAT, DIV_LAT).
REQ-015 In IDLE, start_E with op 0/1 SHALL latch operands and the op, load the counter with MULT_LAT-1, and enter MUL.
REQ-016 In IDLE, start_E with op 2/3 SHALL latch operands and the op, load the counter with DIV_LAT-1, and enter DIV.
REQ-017 In IDLE, start_E with op 4 SHALL write a_E to hi at that edge, with no busy cycles.
REQ-018 In IDLE, start_E with op 5 SHALL write a_E to lo at that edge, with no busy cycles.
REQ-019 Reserved op codes SHALL be ignored.
REQ-020 busy SHALL be high for exactly MULT_LAT or DIV_LAT cycles after the start edge.
REQ-021 Busy duration behaviour:
  - the counter decrements each cycle in MUL/DIV;
  - at count 0 the FSM returns to IDLE and hi/lo update on that same edge;
  - busy falls on that same edge.
REQ-022 Multiply results:
  - MULT: signed 64-bit product, {hi,lo} = a*b;
  - MULTU: unsigned 64-bit product, {hi,lo} = a*b.
REQ-023 DIV/DIVU: lo = quotient (signed: truncated toward zero), hi = remainder (signed: sign of dividend).
REQ-024 Divide by zero SHALL complete with normal latency and leave hi/lo unchanged.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-026 start_E while busy SHALL be ignored; it cannot occur legally because of REQ-027.
REQ-027 stall_md = md_use_D & (busy | (start_E & op_E in {0,1,2,3})); the output is combinational.
REQ-028 A D-stage consumer issued on the cycle busy falls SHALL see updated hi/lo (no stall that cycle).
REQ-029 stall_md SHALL NOT depend on hi/lo values.
REQ-030 Operands SHALL be captured at start; later changes on a_E/b_E SHALL NOT affect the result.

Reset
REQ-031 rst_n low SHALL asynchronously force:
  - FSM to IDLE;
  - counter to 0;
  - busy=0;
  - hi=0, lo=0;
  - operand/op latches to 0.
REQ-032 Reset asserted mid-operation SHALL abort it; no hi/lo update occurs after release.
REQ-033 After rst_n deasserts, the block SHALL accept start_E on the first rising edge.

Structure
REQ-034 Op encodings (MD_MULT..MD_MTLO) and FSM state encodings SHALL live in the shared CPU definitions package.
REQ-035 One sub-module md_arith SHALL hold the combinational 64-bit multiply and 32-bit divide; md_scheduler owns FSM, counter, latches, hi/lo.

Verification
REQ-036 Multiply timing: MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-037 Unsigned divide: DIVU a=100, b=7 -> busy 10 cycles; then lo=14, hi=2.
REQ-038 Signed divide: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 Divide by zero: DIV b=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO -> after 10 busy cycles hi=0x11, lo=0x22.
REQ-040 Stall: md_use_D=1 held during MULT -> stall_md high on the start cycle and all 5 busy cycles, low the cycle busy falls.
REQ-041 Reset abort: rst_n low at busy cycle 3 of MULTU 0xFFFFFFFF*2 -> busy=0, hi=lo=0 immediately and after release.
